// File: rtl/serv_dbus_bridge.sv
// Registered Wishbone bridge for the core data bus: one outstanding classic cycle,
// single-cycle ack back to the core, and a watchdog that turns a silent slave into an error.
module serv_dbus_bridge #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_cpu_adr,
  input  logic [31:0] i_cpu_dat,
  input  logic [3:0]  i_cpu_sel,
  input  logic        i_cpu_we,
  input  logic        i_cpu_cyc,
  output logic [31:0] o_cpu_rdt,
  output logic        o_cpu_ack,
  output logic        o_cpu_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DROP
  } state_e;

  localparam logic [TIMEOUT_W-1:0] WDT_LAST = '1;
  localparam logic [TIMEOUT_W-1:0] WDT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [31:0]          adr_q, adr_d;
  logic [31:0]          dat_q, dat_d;
  logic [3:0]           sel_q, sel_d;
  logic                 we_q, we_d;
  logic [31:0]          rdt_q, rdt_d;
  logic                 err_q, err_d;
  logic                 cyc_q, cyc_d;
  logic                 ack_q, ack_d;
  logic [TIMEOUT_W-1:0] wdt_q, wdt_d;
  logic [TIMEOUT_W-1:0] wdt_inc;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdt_d   = rdt_q;
    err_d   = 1'b0;
    wdt_d   = wdt_q;
    wdt_inc = wdt_q + WDT_ONE;

    case (state_q)
      ST_IDLE: begin
        if (i_cpu_cyc) begin
          adr_d   = i_cpu_adr;
          dat_d   = i_cpu_dat;
          sel_d   = i_cpu_sel;
          we_d    = i_cpu_we;
          wdt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        wdt_d = wdt_inc;
        // Slave error beats ack; any slave response beats the watchdog.
        if (i_wb_err) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (i_wb_ack) begin
          if (!we_q) rdt_d = i_wb_rdt;
          state_d = ST_RESP;
        end else if (wdt_inc == WDT_LAST) begin
          err_d   = 1'b1;
          rdt_d   = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_DROP;
      ST_DROP: begin
        // The acknowledged request may still be held; wait for it to drop.
        if (!i_cpu_cyc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cyc_d = (state_d == ST_REQ);
    ack_d = (state_d == ST_RESP);
  end

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdt_q   <= '0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      ack_q   <= 1'b0;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdt_q   <= rdt_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      ack_q   <= ack_d;
      wdt_q   <= wdt_d;
    end
  end

  assign o_wb_adr  = adr_q;
  assign o_wb_dat  = dat_q;
  assign o_wb_sel  = sel_q;
  assign o_wb_we   = we_q;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = cyc_q;
  assign o_cpu_rdt = rdt_q;
  assign o_cpu_ack = ack_q;
  assign o_cpu_err = err_q;

endmodule

// File: tb/tb_serv_dbus_bridge.sv
// Randomised bench for serv_dbus_bridge: a transaction-level model schedules the expected
// per-cycle outputs, one negedge process compares them, directed cases pin the model.
module tb_serv_dbus_bridge;

  localparam int TW   = 4;
  localparam int TMAX = (1 << TW) - 1;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_cpu_adr, i_cpu_dat;
  logic [3:0]  i_cpu_sel;
  logic        i_cpu_we, i_cpu_cyc;
  logic [31:0] o_cpu_rdt;
  logic        o_cpu_ack, o_cpu_err;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_cyc, o_wb_stb;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack, i_wb_err;

  serv_dbus_bridge #(.TIMEOUT_W(TW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cpu_adr(i_cpu_adr), .i_cpu_dat(i_cpu_dat), .i_cpu_sel(i_cpu_sel),
    .i_cpu_we(i_cpu_we), .i_cpu_cyc(i_cpu_cyc),
    .o_cpu_rdt(o_cpu_rdt), .o_cpu_ack(o_cpu_ack), .o_cpu_err(o_cpu_err),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc_cnt = 0;
  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  // Expected outputs per cycle; absent entries mean idle bus, no ack.
  bit          exp_cyc [int];
  bit          exp_ack [int];
  bit          exp_err [int];
  logic [31:0] exp_rdt [int];
  logic [31:0] exp_adr [int];
  logic [31:0] exp_dat [int];
  logic [3:0]  exp_sel [int];
  bit          exp_we  [int];
  logic [31:0] m_rdt = '0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc_cnt, act, exp);
  endtask

  bit          checking = 1'b0;
  int          run_len = 0, last_run = 0, last_rise_cyc = -1, last_ack_cyc = -1, ack_count = 0;
  logic [31:0] last_ack_rdt = '0;
  logic        last_ack_err = 1'b0;

  always @(negedge i_clk) begin
    if (checking) begin
      int c;
      bit ec;
      c  = cyc_cnt;
      ec = exp_cyc.exists(c) ? exp_cyc[c] : 1'b0;
      check("wb_cyc", o_wb_cyc, ec);
      check("wb_stb", o_wb_stb, ec);
      check("cpu_ack", o_cpu_ack, exp_ack.exists(c) ? exp_ack[c] : 1'b0);
      check("cpu_err", o_cpu_err, exp_err.exists(c) ? exp_err[c] : 1'b0);
      if (exp_rdt.exists(c)) check("cpu_rdt", o_cpu_rdt, exp_rdt[c]);
      if (ec) begin
        check("wb_adr", o_wb_adr, exp_adr[c]);
        check("wb_dat", o_wb_dat, exp_dat[c]);
        check("wb_sel", o_wb_sel, exp_sel[c]);
        check("wb_we",  o_wb_we,  exp_we[c]);
      end
      if (o_wb_cyc === 1'b1) begin
        if (run_len == 0) last_rise_cyc = c;
        run_len++;
      end else if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
      if (o_cpu_ack === 1'b1) begin
        ack_count++;
        last_ack_cyc = c;
        last_ack_rdt = o_cpu_rdt;
        last_ack_err = o_cpu_err;
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // NOTE: inputs are driven with blocking assignments #1 after the edge, so the DUT
  // samples them cleanly on the following edge.
  task automatic rand_cpu();
    i_cpu_adr = $urandom;
    i_cpu_dat = $urandom;
    i_cpu_sel = 4'($urandom);
    i_cpu_we  = 1'($urandom);
  endtask

  task automatic noise();
    i_wb_ack = 1'($urandom_range(0, 1));
    i_wb_err = 1'($urandom_range(0, 1));
    i_wb_rdt = $urandom;
  endtask

  // One core transfer: slave answers (kind) after d wait cycles unless the watchdog fires
  // first; core holds cyc h cycles past the ack, then idles g cycles.
  task automatic do_txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input bit we, input int d, input int kind, input logic [31:0] rdata,
                        input int h, input int g, output int n_out);
    int          n, l, a;
    bit          to, e;
    logic [31:0] new_rdt;
    n     = cyc_cnt;
    n_out = n;
    i_cpu_cyc = 1'b1;
    i_cpu_adr = adr;
    i_cpu_dat = dat;
    i_cpu_sel = sel;
    i_cpu_we  = we;
    i_wb_ack  = 1'b0;
    i_wb_err  = 1'b0;

    to      = (kind == K_NONE) || (d + 1 > TMAX);
    l       = to ? TMAX : d + 1;
    e       = to || (kind == K_ERR) || (kind == K_BOTH);
    new_rdt = to ? 32'h0 : ((kind == K_ACK && !we) ? rdata : m_rdt);
    a       = n + l + 1;
    exp_rdt[n] = m_rdt;
    for (int c = n + 1; c <= n + l; c++) begin
      exp_cyc[c] = 1'b1;
      exp_adr[c] = adr;
      exp_dat[c] = dat;
      exp_sel[c] = sel;
      exp_we[c]  = we;
      exp_rdt[c] = m_rdt;
    end
    exp_ack[a] = 1'b1;
    exp_err[a] = e;
    exp_rdt[a] = new_rdt;
    m_rdt      = new_rdt;
    step();

    for (int k = 1; k <= l; k++) begin
      rand_cpu();
      i_wb_rdt = $urandom;
      if (!to && k == l) begin
        i_wb_ack = (kind != K_ERR);
        i_wb_err = (kind != K_ACK);
        i_wb_rdt = rdata;
      end else begin
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
      end
      step();
    end

    for (int k = 0; k <= h; k++) begin
      noise();
      rand_cpu();
      exp_rdt[cyc_cnt] = m_rdt;
      step();
    end
    for (int k = 0; k <= g; k++) begin
      i_cpu_cyc = 1'b0;
      noise();
      rand_cpu();
      exp_rdt[cyc_cnt] = m_rdt;
      step();
    end
  endtask

  task automatic reset_mid_txn();
    int n, acks0;
    n = cyc_cnt;
    i_cpu_cyc = 1'b1;
    i_cpu_adr = 32'h0000_3008;
    i_cpu_dat = 32'hA5A5_5A5A;
    i_cpu_sel = 4'hF;
    i_cpu_we  = 1'b1;
    i_wb_ack  = 1'b0;
    i_wb_err  = 1'b0;
    exp_rdt[n] = m_rdt;
    for (int c = n + 1; c <= n + 2; c++) begin
      exp_cyc[c] = 1'b1;
      exp_adr[c] = 32'h0000_3008;
      exp_dat[c] = 32'hA5A5_5A5A;
      exp_sel[c] = 4'hF;
      exp_we[c]  = 1'b1;
      exp_rdt[c] = m_rdt;
    end
    acks0 = ack_count;
    step();
    rand_cpu();
    step();
    i_rst = 1'b1;
    step();
    i_rst     = 1'b0;
    i_cpu_cyc = 1'b0;
    m_rdt     = '0;
    exp_rdt[cyc_cnt] = '0;
    check("rst_mid_wb_cyc", o_wb_cyc, 1'b0);
    check("rst_mid_ack", o_cpu_ack, 1'b0);
    check("rst_mid_adr", o_wb_adr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      noise();
      exp_rdt[cyc_cnt] = '0;
      step();
    end
    check("rst_mid_no_ack", ack_count, acks0);
  endtask

  initial begin
    int n, a, r, d, kind;
    i_rst     = 1'b1;
    i_cpu_cyc = 1'b0;
    i_cpu_adr = '0;
    i_cpu_dat = '0;
    i_cpu_sel = '0;
    i_cpu_we  = 1'b0;
    i_wb_rdt  = '0;
    i_wb_ack  = 1'b0;
    i_wb_err  = 1'b0;
    repeat (3) step();
    check("rst_wb_cyc", o_wb_cyc, 1'b0);
    check("rst_wb_stb", o_wb_stb, 1'b0);
    check("rst_wb_we",  o_wb_we,  1'b0);
    check("rst_cpu_ack", o_cpu_ack, 1'b0);
    check("rst_cpu_err", o_cpu_err, 1'b0);
    check("rst_wb_adr", o_wb_adr, 32'h0);
    check("rst_wb_dat", o_wb_dat, 32'h0);
    check("rst_wb_sel", o_wb_sel, 4'h0);
    check("rst_cpu_rdt", o_cpu_rdt, 32'h0);
    i_rst    = 1'b0;
    checking = 1'b1;
    step();

    do_txn(32'h0000_1004, 32'h0, 4'hF, 1'b0, 0, K_ACK, 32'hDEAD_BEEF, 0, 0, n);
    check("load_latency", last_ack_cyc - n, 2);
    check("load_cyc_len", last_run, 1);
    check("load_rdt", last_ack_rdt, 32'hDEAD_BEEF);
    check("load_err", last_ack_err, 1'b0);

    do_txn(32'h0000_2002, 32'h1234_5678, 4'b1100, 1'b1, 3, K_ACK, 32'h1111_2222, 0, 1, n);
    check("store_cyc_len", last_run, 4);
    check("store_rdt_kept", last_ack_rdt, 32'hDEAD_BEEF);
    check("store_err", last_ack_err, 1'b0);

    do_txn(32'h0000_4000, 32'h0, 4'hF, 1'b0, 0, K_NONE, 32'h0, 0, 0, n);
    check("timeout_cyc_len", last_run, 15);
    check("timeout_err", last_ack_err, 1'b1);
    check("timeout_rdt", last_ack_rdt, 32'h0);

    do_txn(32'h0000_1008, 32'h0, 4'hF, 1'b0, 2, K_ACK, 32'hCAFE_F00D, 0, 0, n);
    do_txn(32'h0000_100C, 32'h0, 4'hF, 1'b0, 1, K_BOTH, 32'h5555_AAAA, 0, 0, n);
    check("both_err", last_ack_err, 1'b1);
    check("both_rdt_kept", last_ack_rdt, 32'hCAFE_F00D);

    do_txn(32'h0000_1010, 32'h0, 4'hF, 1'b0, 14, K_ACK, 32'h0BAD_F00D, 0, 0, n);
    check("lastcyc_err", last_ack_err, 1'b0);
    check("lastcyc_len", last_run, 15);
    check("lastcyc_rdt", last_ack_rdt, 32'h0BAD_F00D);

    do_txn(32'h0000_1014, 32'h0, 4'hF, 1'b0, 0, K_ACK, 32'h7777_0001, 3, 0, n);
    a = last_ack_cyc;
    do_txn(32'h0000_1018, 32'h0, 4'hF, 1'b0, 0, K_ACK, 32'h7777_0002, 0, 0, n);
    check("held_next_rise", last_rise_cyc - a, 6);

    reset_mid_txn();
    do_txn(32'h0000_1020, 32'h0, 4'hF, 1'b0, 1, K_ACK, 32'h600D_0001, 0, 0, n);
    check("post_rst_rdt", last_ack_rdt, 32'h600D_0001);
    check("post_rst_err", last_ack_err, 1'b0);

    for (int t = 0; t < 150; t++) begin
      r    = $urandom_range(0, 10);
      kind = (r < 7) ? K_ACK : (r < 8) ? K_ERR : (r < 9) ? K_BOTH : (r < 10) ? K_NONE : K_ACK;
      d    = $urandom_range(0, 18);
      do_txn($urandom, $urandom, 4'($urandom), 1'($urandom), d, kind, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), n);
    end

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serv_dbus_bridge.md
# serv_dbus_bridge

Registered Wishbone bridge between the core's data-bus master (the memory interface that drives address, write data and byte selects) and the external data bus. It captures each request and replays it as a clean one-outstanding Wishbone classic cycle. It returns the read word and a single-cycle acknowledge to the core. A watchdog converts a silent slave into an error response, so the core never hangs on a bad address.

## Interface
- TIMEOUT_W, default 8: width of the watchdog counter; a bus cycle is aborted after 2^TIMEOUT_W-1 cycles without response (legal range 2..16).
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous active-high reset
- i_cpu_adr  in  32  core request byte address (bits [1:0] forwarded unchanged)
- i_cpu_dat  in  32  core write data
- i_cpu_sel  in  4  core byte selects
- i_cpu_we  in  1  1 = store, 0 = load
- i_cpu_cyc  in  1  core request, held high until acknowledged
- o_cpu_rdt  out  32  read data, valid while o_cpu_ack=1
- o_cpu_ack  out  1  one-cycle completion pulse
- o_cpu_err  out  1  bus error/timeout, asserted only together with o_cpu_ack
- o_wb_adr  out  32  registered bus address
- o_wb_dat  out  32  registered bus write data
- o_wb_sel  out  4  registered byte selects
- o_wb_we  out  1  registered write enable
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  1  strobe, identical to o_wb_cyc
- i_wb_rdt  in  32  slave read data
- i_wb_ack  in  1  slave acknowledge
- i_wb_err  in  1  slave error

## Operation
- States: IDLE, REQ, RESP, DROP.
- IDLE: when i_cpu_cyc=1, latch adr/dat/sel/we into the o_wb_* registers, clear the watchdog, and go to REQ. Otherwise stay in IDLE.
- REQ: o_wb_cyc=o_wb_stb=1. Registered request outputs are frozen. The watchdog increments every cycle.
  - i_wb_err=1: go to RESP with the error flag set. Error wins over a simultaneous ack.
  - i_wb_ack=1 (no err): if !o_wb_we, capture i_wb_rdt into the rdt register. Go to RESP with the error flag clear.
  - Watchdog at 2^TIMEOUT_W-1 with no ack/err: go to RESP with the error flag set and rdt cleared to 0. An ack or err in that same cycle takes priority over the timeout.
- RESP: o_wb_cyc=0. o_cpu_ack=1 for exactly one cycle. o_cpu_err=error flag. Next state is DROP.
- DROP: wait for i_cpu_cyc=0, then go to IDLE. A request still held from the acknowledged transfer is never reissued.
- i_wb_ack and i_wb_err outside REQ are ignored.
- o_cpu_rdt holds its last value between transfers. Stores and errors from the slave leave it unchanged. A timeout zeroes it.
- Watchdog arithmetic: unsigned TIMEOUT_W bits. It is only compared for equality, so it never wraps.

## Timing
- Reset (synchronous): state=IDLE. o_wb_cyc, o_wb_stb, o_wb_we, o_cpu_ack and o_cpu_err are 0. o_wb_adr, o_wb_dat, o_wb_sel, o_cpu_rdt and the watchdog are 0.
- Reset mid-transfer: o_wb_cyc drops on the reset edge. No o_cpu_ack is generated for the aborted transfer.
- i_cpu_cyc rises in cycle N: o_wb_cyc=1 from N+1.
- Slave ack in cycle M (M≥N+1): o_wb_cyc=0 and o_cpu_ack=1 in M+1. The minimum request-to-ack latency is 2 cycles.
- Timeout: o_wb_cyc is high for 2^TIMEOUT_W-1 cycles. o_cpu_ack and o_cpu_err follow in the next cycle.
- Back-to-back: with i_cpu_cyc low at ack+1, IDLE is reached at ack+2. The earliest next o_wb_cyc is ack+3.
- All outputs are registered. There is no combinational path from i_wb_* to o_cpu_* or from i_cpu_* to o_wb_*.

## Test plan
- Load: i_cpu_cyc=1, adr=0x0000_1004, we=0, slave acks in the first REQ cycle with rdt=0xDEAD_BEEF -> o_wb_cyc high for 1 cycle, o_cpu_ack pulse 2 cycles after the request with o_cpu_rdt=0xDEAD_BEEF and o_cpu_err=0.
- Store: adr=0x0000_2002, dat=0x1234_5678, sel=4'b1100, we=1, slave acks after 3 wait cycles -> o_wb_adr/dat/sel/we match and are stable for all 4 cycles, o_cpu_ack=1, o_cpu_rdt unchanged.
- Timeout with TIMEOUT_W=4 and no slave response -> o_wb_cyc high for exactly 15 cycles, then o_cpu_ack=o_cpu_err=1 for one cycle with o_cpu_rdt=0.
- Error priority: i_wb_ack=i_wb_err=1 in the same cycle -> o_cpu_err=1. An ack on the final watchdog cycle -> o_cpu_err=0 and the data is captured.
- Held request: i_cpu_cyc stays high 3 cycles after o_cpu_ack -> no second o_wb_cyc until i_cpu_cyc has been low for one cycle.
- Reset during REQ -> o_wb_cyc=0 after the reset edge, no o_cpu_ack pulse, and a new request after reset completes normally.
